bsram_port_arbiter: RTL and testbench
=====================================

# bsram_port_arbiter

Two-requester arbiter and sequencer that shares one byte-enabled block RAM (BSRAM_byte_en) between two masters, such as a core data port and a loader/DMA port. It grants at most one read or write per cycle with round-robin fairness and drives the RAM's single read and single write port. Read responses are routed back to their owner one cycle later. A bounded lock lets one requester hold the RAM for read-modify-write sequences.

## Interface
Parameters:
- DATA_WIDTH, 32, RAM word width; multiple of 8
- ADDR_WIDTH, 8, RAM word address width
- MAX_LOCK_CYCLES, 16, maximum consecutive cycles one requester may hold a lock; ≥1

Ports (n = 0,1; NB = DATA_WIDTH/8):
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- reqValid_n  in  1  requester n presents a request
- reqReady_n  out  1  request n accepted this cycle (valid & ready = accepted)
- reqWrite_n  in  1  1 = write, 0 = read
- reqByteEn_n  in  NB  write byte enables; ignored for reads
- reqAddress_n  in  ADDR_WIDTH  word address
- reqWriteData_n  in  DATA_WIDTH  write data
- reqLock_n  in  1  hold the grant after this request
- respValid_n  out  1  read data for requester n is valid this cycle
- respData_n  out  DATA_WIDTH  read data; defined only while respValid_n is high
- memReadEnable  out  1  to BSRAM_byte_en readEnable
- memReadAddress  out  ADDR_WIDTH  to readAddress
- memReadData  in  DATA_WIDTH  from readData; valid one cycle after memReadEnable
- memWriteEnable  out  1  to writeEnable
- memWriteByteEnable  out  NB  to writeByteEnable
- memWriteAddress  out  ADDR_WIDTH  to writeAddress
- memWriteData  out  DATA_WIDTH  to writeData

## Operation
- State machine: ARB, LOCK0, LOCK1. Registers: the round-robin pointer rrPtr, a lock counter (width clog2(MAX_LOCK_CYCLES+1)), and a response pipeline (rdPending, rdOwner).
- ARB:
  - Only one reqValid_n high: grant n.
  - Both high: grant rrPtr.
  - After any grant, rrPtr is set to the other requester.
- LOCKn: only requester n can be granted. reqReady of the other requester is 0.
- Entering a lock: in ARB, if the granted request has reqLock_n=1, go to LOCKn and clear the lock counter.
- While in LOCKn:
  - The counter increments every cycle.
  - An accepted request from n with reqLock_n=0 returns the machine to ARB.
  - When the counter reaches MAX_LOCK_CYCLES-1, the machine returns to ARB regardless of reqLock_n (forced release). An accepted request in that cycle is still serviced.
  - On any exit from LOCKn, rrPtr is set to the other requester.
- Accepted read: memReadEnable=1 and memReadAddress=reqAddress_n in the same cycle. Set rdPending=1 and rdOwner=n.
- Accepted write:
  - memWriteEnable=1; memWriteByteEnable=reqByteEn_n.
  - memWriteAddress and memWriteData are the request's fields.
  - Nothing is returned to the requester.
- A write with reqByteEn_n all zero is still accepted and consumes the grant; the RAM is unchanged.
- Response: when rdPending=1, assert respValid_{rdOwner} and drive memReadData to that requester's respData. Responses cannot be stalled.
- No grant: all mem enables are 0. Address and data outputs are don't-care, but must not toggle when unused (drive 0).

## Timing
- Grant and reqReady_n are combinational from reqValid_n and registered state. Requests are accepted in the same cycle.
- Read latency: accepted at edge k, so respValid at cycle k+1. Back-to-back reads from the same or alternating requesters give one response per cycle.
- A write accepted at edge k is visible to a read accepted at edge k+1 or later.
- While reset is low, all outputs are forced 0:
  - reqReady_n, respValid_n, respData_n
  - all mem* outputs
- Reset values: state=ARB, rrPtr=0 (requester 0 wins the first tie), lock counter=0, rdPending=0.
- Reset asserted mid-read: the pending response is discarded and no respValid follows reset release.
- Reset asserted mid-lock: the lock is dropped and the machine is in ARB after release.
- At most one mem enable is high per cycle. memReadEnable and memWriteEnable are never both 1.

## Test plan
- Both requesters issue continuous reads to 0x10 and 0x20 after reset:
  - grants alternate 0,1,0,1
  - each respValid_n arrives one cycle after its acceptance with the correct word.
- Requester 0 writes 0xAABBCCDD to 0x05 with byte enables 0b0101, then reads 0x05 (prior contents 0x11223344):
  - the response is 0x11BB33DD
  - requester 1's concurrent request waits only one cycle.
- Requester 1 locks (reqLock_1=1) for a read then a write to 0x07, while requester 0 stays valid:
  - reqReady_0 is 0 until requester 1's unlocked request is accepted
  - requester 0 is granted the next cycle.
- Requester 0 holds reqLock_0=1 continuously with MAX_LOCK_CYCLES=4 and requester 1 valid:
  - forced release after 4 locked cycles
  - requester 1 is granted next.
- Reset is pulled low on the cycle after an accepted read:
  - respValid stays 0
  - all mem outputs read 0 during reset
  - after release the first tie goes to requester 0.

Source files
------------

// File: rtl/bsram_port_arbiter_if.sv
// Request/response and RAM-side signal bundle for bsram_port_arbiter.
// Suffix _0/_1 selects the requester; mem* signals face BSRAM_byte_en.
interface bsram_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
);
    localparam int unsigned NB = DATA_WIDTH / 8;

    logic                  reqValid_0;
    logic                  reqReady_0;
    logic                  reqWrite_0;
    logic [NB-1:0]         reqByteEn_0;
    logic [ADDR_WIDTH-1:0] reqAddress_0;
    logic [DATA_WIDTH-1:0] reqWriteData_0;
    logic                  reqLock_0;
    logic                  respValid_0;
    logic [DATA_WIDTH-1:0] respData_0;

    logic                  reqValid_1;
    logic                  reqReady_1;
    logic                  reqWrite_1;
    logic [NB-1:0]         reqByteEn_1;
    logic [ADDR_WIDTH-1:0] reqAddress_1;
    logic [DATA_WIDTH-1:0] reqWriteData_1;
    logic                  reqLock_1;
    logic                  respValid_1;
    logic [DATA_WIDTH-1:0] respData_1;

    logic                  memReadEnable;
    logic [ADDR_WIDTH-1:0] memReadAddress;
    logic [DATA_WIDTH-1:0] memReadData;
    logic                  memWriteEnable;
    logic [NB-1:0]         memWriteByteEnable;
    logic [ADDR_WIDTH-1:0] memWriteAddress;
    logic [DATA_WIDTH-1:0] memWriteData;

    modport slave (
        input  reqValid_0, reqWrite_0, reqByteEn_0, reqAddress_0, reqWriteData_0, reqLock_0,
        input  reqValid_1, reqWrite_1, reqByteEn_1, reqAddress_1, reqWriteData_1, reqLock_1,
        input  memReadData,
        output reqReady_0, respValid_0, respData_0,
        output reqReady_1, respValid_1, respData_1,
        output memReadEnable, memReadAddress,
        output memWriteEnable, memWriteByteEnable, memWriteAddress, memWriteData
    );

    modport master (
        output reqValid_0, reqWrite_0, reqByteEn_0, reqAddress_0, reqWriteData_0, reqLock_0,
        output reqValid_1, reqWrite_1, reqByteEn_1, reqAddress_1, reqWriteData_1, reqLock_1,
        output memReadData,
        input  reqReady_0, respValid_0, respData_0,
        input  reqReady_1, respValid_1, respData_1,
        input  memReadEnable, memReadAddress,
        input  memWriteEnable, memWriteByteEnable, memWriteAddress, memWriteData
    );
endinterface

// File: rtl/bsram_port_arbiter.sv
// Round-robin arbiter sharing one byte-enabled block RAM between two requesters,
// with a bounded lock for read-modify-write and a one-cycle read response path.
module bsram_port_arbiter #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 8,
    parameter int unsigned MAX_LOCK_CYCLES = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    bsram_port_arbiter_if.slave  bus
);
    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned CW = $clog2(MAX_LOCK_CYCLES + 1);

    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

    state_t        state;
    logic          rr_ptr;
    logic [CW-1:0] lock_cnt;
    logic          rd_pending;
    logic          rd_owner;

    logic                  grant_valid;
    logic                  grant_id;
    logic                  g_write;
    logic                  g_lock;
    logic [NB-1:0]         g_be;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  rd_grant;
    logic                  wr_grant;

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        case (state)
            ARB: begin
                if (bus.reqValid_0 && bus.reqValid_1) begin
                    grant_valid = 1'b1;
                    grant_id    = rr_ptr;
                end else if (bus.reqValid_0) begin
                    grant_valid = 1'b1;
                end else if (bus.reqValid_1) begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b1;
                end
            end
            LOCK0: grant_valid = bus.reqValid_0;
            LOCK1: begin
                grant_valid = bus.reqValid_1;
                grant_id    = 1'b1;
            end
            default: grant_valid = 1'b0;
        endcase
        // Reset low gates every grant so all outputs read 0 while held in reset.
        grant_valid = grant_valid & reset;

        g_write = grant_id ? bus.reqWrite_1     : bus.reqWrite_0;
        g_lock  = grant_id ? bus.reqLock_1      : bus.reqLock_0;
        g_be    = grant_id ? bus.reqByteEn_1    : bus.reqByteEn_0;
        g_addr  = grant_id ? bus.reqAddress_1   : bus.reqAddress_0;
        g_data  = grant_id ? bus.reqWriteData_1 : bus.reqWriteData_0;
        rd_grant = grant_valid & ~g_write;
        wr_grant = grant_valid &  g_write;
    end

    assign bus.reqReady_0 = grant_valid & ~grant_id;
    assign bus.reqReady_1 = grant_valid &  grant_id;

    assign bus.memReadEnable      = rd_grant;
    assign bus.memReadAddress     = rd_grant ? g_addr : '0;
    assign bus.memWriteEnable     = wr_grant;
    assign bus.memWriteByteEnable = wr_grant ? g_be   : '0;
    assign bus.memWriteAddress    = wr_grant ? g_addr : '0;
    assign bus.memWriteData       = wr_grant ? g_data : '0;

    assign bus.respValid_0 = reset & rd_pending & ~rd_owner;
    assign bus.respValid_1 = reset & rd_pending &  rd_owner;
    assign bus.respData_0  = bus.respValid_0 ? bus.memReadData : '0;
    assign bus.respData_1  = bus.respValid_1 ? bus.memReadData : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ARB;
            rr_ptr     <= 1'b0;
            lock_cnt   <= '0;
            rd_pending <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            rd_pending <= rd_grant;
            if (rd_grant) begin
                rd_owner <= grant_id;
            end
            case (state)
                ARB: begin
                    if (grant_valid) begin
                        rr_ptr <= ~grant_id;
                        if (g_lock) begin
                            state    <= grant_id ? LOCK1 : LOCK0;
                            lock_cnt <= '0;
                        end
                    end
                end
                LOCK0, LOCK1: begin
                    lock_cnt <= lock_cnt + CW'(1);
                    if ((grant_valid && !g_lock) || lock_cnt == CW'(MAX_LOCK_CYCLES - 1)) begin
                        state    <= ARB;
                        rr_ptr   <= (state == LOCK0);
                        lock_cnt <= '0;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_bsram_port_arbiter.sv
// Directed bench for bsram_port_arbiter: a RAM stand-in, a per-cycle reference
// model of grants/responses, and literal checks for the planned scenarios.
module tb_bsram_port_arbiter;
    localparam int MAXL = 4;

    logic clock;
    logic reset;

    bsram_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus();

    bsram_port_arbiter #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8),
        .MAX_LOCK_CYCLES(MAXL)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            5:       return 32'h11223344;
            7:       return 32'h07070707;
            16:      return 32'hCAFE0010;
            32:      return 32'hBEEF0020;
            default: return 32'(i) * 32'h01010101;
        endcase
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RAM stand-in: registered read, byte-enabled write
    logic [31:0] ram [256];
    logic [31:0] shadow [256];
    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]    = init_word(i);
            shadow[i] = init_word(i);
        end
    end

    always @(posedge clock) begin
        if (bus.memReadEnable) bus.memReadData <= ram[bus.memReadAddress];
        if (bus.memWriteEnable) begin
            for (int b = 0; b < 4; b++)
                if (bus.memWriteByteEnable[b])
                    ram[bus.memWriteAddress][8*b +: 8] = bus.memWriteData[8*b +: 8];
        end
    end

    // Reference model: who owns a lock, how long it has been held, whose turn a tie is.
    int          rr_m = 0;
    int          lock_m = -1;
    int          held_m = 0;
    int          pend_owner = -1;
    logic [31:0] pend_data = '0;
    int          g;
    logic        rw, rl, re, we;
    logic [3:0]  rbe;
    logic [7:0]  ra;
    logic [31:0] rd;
    logic [1:0]  v;

    always @(negedge clock) begin
        if (!reset) begin
            rr_m = 0; lock_m = -1; held_m = 0; pend_owner = -1;
            chk1("rst_ready0", bus.reqReady_0, 1'b0);
            chk1("rst_ready1", bus.reqReady_1, 1'b0);
            chk1("rst_resp0", bus.respValid_0, 1'b0);
            chk1("rst_resp1", bus.respValid_1, 1'b0);
            chk32("rst_rdata0", bus.respData_0, 32'h0);
            chk32("rst_rdata1", bus.respData_1, 32'h0);
            chk1("rst_mre", bus.memReadEnable, 1'b0);
            chk1("rst_mwe", bus.memWriteEnable, 1'b0);
            chk32("rst_mra", 32'(bus.memReadAddress), 32'h0);
            chk32("rst_mwa", 32'(bus.memWriteAddress), 32'h0);
            chk32("rst_mwd", bus.memWriteData, 32'h0);
            chk32("rst_mbe", 32'(bus.memWriteByteEnable), 32'h0);
        end else begin
            v = {bus.reqValid_1, bus.reqValid_0};
            g = -1;
            if (lock_m >= 0) begin
                if (v[lock_m]) g = lock_m;
            end else if (v == 2'b11) g = rr_m;
            else if (v[0]) g = 0;
            else if (v[1]) g = 1;

            rw  = (g == 1) ? bus.reqWrite_1     : bus.reqWrite_0;
            rl  = (g == 1) ? bus.reqLock_1      : bus.reqLock_0;
            rbe = (g == 1) ? bus.reqByteEn_1    : bus.reqByteEn_0;
            ra  = (g == 1) ? bus.reqAddress_1   : bus.reqAddress_0;
            rd  = (g == 1) ? bus.reqWriteData_1 : bus.reqWriteData_0;
            re  = (g >= 0) && !rw;
            we  = (g >= 0) && rw;

            chk1("m_ready0", bus.reqReady_0, g == 0);
            chk1("m_ready1", bus.reqReady_1, g == 1);
            chk1("m_mre", bus.memReadEnable, re);
            chk32("m_mra", 32'(bus.memReadAddress), 32'(re ? ra : 8'h0));
            chk1("m_mwe", bus.memWriteEnable, we);
            chk32("m_mbe", 32'(bus.memWriteByteEnable), 32'(we ? rbe : 4'h0));
            chk32("m_mwa", 32'(bus.memWriteAddress), 32'(we ? ra : 8'h0));
            chk32("m_mwd", bus.memWriteData, we ? rd : 32'h0);
            chk1("m_resp0", bus.respValid_0, pend_owner == 0);
            chk1("m_resp1", bus.respValid_1, pend_owner == 1);
            if (pend_owner == 0) chk32("m_rdata0", bus.respData_0, pend_data);
            if (pend_owner == 1) chk32("m_rdata1", bus.respData_1, pend_data);

            pend_owner = -1;
            if (re) begin
                pend_owner = g;
                pend_data  = shadow[ra];
            end
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (rbe[b]) shadow[ra][8*b +: 8] = rd[8*b +: 8];
            end
            if (lock_m < 0) begin
                if (g >= 0) begin
                    rr_m = 1 - g;
                    if (rl) begin
                        lock_m = g;
                        held_m = 0;
                    end
                end
            end else begin
                held_m++;
                if ((g >= 0 && !rl) || held_m == MAXL) begin
                    rr_m   = 1 - lock_m;
                    lock_m = -1;
                end
            end
        end
    end

    task automatic req0(input logic vv, input logic w, input logic [3:0] be,
                        input logic [7:0] a, input logic [31:0] d, input logic l);
        bus.reqValid_0 = vv; bus.reqWrite_0 = w; bus.reqByteEn_0 = be;
        bus.reqAddress_0 = a; bus.reqWriteData_0 = d; bus.reqLock_0 = l;
    endtask

    task automatic req1(input logic vv, input logic w, input logic [3:0] be,
                        input logic [7:0] a, input logic [31:0] d, input logic l);
        bus.reqValid_1 = vv; bus.reqWrite_1 = w; bus.reqByteEn_1 = be;
        bus.reqAddress_1 = a; bus.reqWriteData_1 = d; bus.reqLock_1 = l;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        req0(0, 0, 4'h0, 8'h00, 32'h0, 0);
        req1(0, 0, 4'h0, 8'h00, 32'h0, 0);
        @(negedge clock);
        chk1("reset_ready0", bus.reqReady_0, 1'b0);
        cyc();
        cyc();
        reset = 1'b1;

        // Continuous reads from both: alternate grants, one response per cycle
        req0(1, 0, 4'h0, 8'h10, 32'h0, 0);
        req1(1, 0, 4'h0, 8'h20, 32'h0, 0);
        @(negedge clock);
        chk1("t1_c0_ready0", bus.reqReady_0, 1'b1);
        chk1("t1_c0_ready1", bus.reqReady_1, 1'b0);
        cyc();
        @(negedge clock);
        chk1("t1_c1_ready1", bus.reqReady_1, 1'b1);
        chk1("t1_c1_resp0", bus.respValid_0, 1'b1);
        chk32("t1_c1_rdata0", bus.respData_0, 32'hCAFE0010);
        cyc();
        @(negedge clock);
        chk1("t1_c2_ready0", bus.reqReady_0, 1'b1);
        chk32("t1_c2_rdata1", bus.respData_1, 32'hBEEF0020);
        cyc();
        @(negedge clock);
        chk1("t1_c3_ready1", bus.reqReady_1, 1'b1);
        cyc();
        req0(0, 0, 4'h0, 8'h00, 32'h0, 0);
        req1(0, 0, 4'h0, 8'h00, 32'h0, 0);
        @(negedge clock);
        chk1("t1_c4_resp1", bus.respValid_1, 1'b1);
        cyc();

        // Partial write then read back; requester 1 waits one cycle
        req0(1, 1, 4'b0101, 8'h05, 32'hAABBCCDD, 0);
        req1(1, 0, 4'h0, 8'h07, 32'h0, 0);
        @(negedge clock);
        chk1("t2_wr_ready0", bus.reqReady_0, 1'b1);
        chk1("t2_wr_mwe", bus.memWriteEnable, 1'b1);
        chk32("t2_wr_mbe", 32'(bus.memWriteByteEnable), 32'h5);
        chk32("t2_wr_mwd", bus.memWriteData, 32'hAABBCCDD);
        cyc();
        req0(1, 0, 4'h0, 8'h05, 32'h0, 0);
        @(negedge clock);
        chk1("t2_r1_ready1", bus.reqReady_1, 1'b1);
        chk1("t2_r1_ready0", bus.reqReady_0, 1'b0);
        cyc();
        req1(0, 0, 4'h0, 8'h00, 32'h0, 0);
        @(negedge clock);
        chk1("t2_rd_ready0", bus.reqReady_0, 1'b1);
        chk32("t2_rdata1", bus.respData_1, 32'h07070707);
        cyc();
        req0(0, 0, 4'h0, 8'h00, 32'h0, 0);
        @(negedge clock);
        chk1("t2_resp0", bus.respValid_0, 1'b1);
        chk32("t2_rdata0", bus.respData_0, 32'h11BB33DD);
        cyc();

        // Requester 1 locks for read then write; requester 0 stalled until release
        req1(1, 0, 4'h0, 8'h07, 32'h0, 1);
        req0(1, 0, 4'h0, 8'h10, 32'h0, 0);
        @(negedge clock);
        chk1("t3_l0_ready1", bus.reqReady_1, 1'b1);
        chk1("t3_l0_ready0", bus.reqReady_0, 1'b0);
        cyc();
        req1(1, 1, 4'hF, 8'h07, 32'h12345678, 0);
        @(negedge clock);
        chk1("t3_l1_ready1", bus.reqReady_1, 1'b1);
        chk1("t3_l1_ready0", bus.reqReady_0, 1'b0);
        chk32("t3_l1_rdata1", bus.respData_1, 32'h07070707);
        cyc();
        req1(0, 0, 4'h0, 8'h00, 32'h0, 0);
        @(negedge clock);
        chk1("t3_after_ready0", bus.reqReady_0, 1'b1);
        cyc();
        req0(1, 0, 4'h0, 8'h07, 32'h0, 0);
        @(negedge clock);
        chk32("t3_rdata0_10", bus.respData_0, 32'hCAFE0010);
        cyc();
        // Zero byte-enable write still takes the grant but leaves the word intact
        req0(0, 0, 4'h0, 8'h00, 32'h0, 0);
        req1(1, 1, 4'h0, 8'h10, 32'hFFFFFFFF, 0);
        @(negedge clock);
        chk32("t3_rdata0_07", bus.respData_0, 32'h12345678);
        chk1("t3_be0_ready1", bus.reqReady_1, 1'b1);
        chk1("t3_be0_mwe", bus.memWriteEnable, 1'b1);
        cyc();

        // Requester 0 holds the lock; forced release after MAXL locked cycles
        req0(1, 0, 4'h0, 8'h10, 32'h0, 1);
        req1(1, 0, 4'h0, 8'h20, 32'h0, 0);
        for (int i = 0; i <= MAXL; i++) begin
            @(negedge clock);
            chk1($sformatf("t4_c%0d_ready0", i), bus.reqReady_0, 1'b1);
            chk1($sformatf("t4_c%0d_ready1", i), bus.reqReady_1, 1'b0);
            cyc();
        end
        @(negedge clock);
        chk1("t4_rel_ready1", bus.reqReady_1, 1'b1);
        chk1("t4_rel_ready0", bus.reqReady_0, 1'b0);
        cyc();
        req0(0, 0, 4'h0, 8'h00, 32'h0, 0);
        req1(0, 0, 4'h0, 8'h00, 32'h0, 0);
        @(negedge clock);
        chk32("t4_rdata1", bus.respData_1, 32'hBEEF0020);
        cyc();

        // Reset pulled low right after an accepted read
        req0(1, 0, 4'h0, 8'h20, 32'h0, 0);
        @(negedge clock);
        chk1("t5_rd_ready0", bus.reqReady_0, 1'b1);
        cyc();
        reset = 1'b0;
        req0(1, 0, 4'h0, 8'h10, 32'h0, 0);
        req1(1, 1, 4'hF, 8'h30, 32'hDEADBEEF, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk1($sformatf("t5_r%0d_resp0", i), bus.respValid_0, 1'b0);
            chk1($sformatf("t5_r%0d_mwe", i), bus.memWriteEnable, 1'b0);
            chk32($sformatf("t5_r%0d_mwd", i), bus.memWriteData, 32'h0);
            cyc();
        end
        reset = 1'b1;
        req1(1, 0, 4'h0, 8'h20, 32'h0, 0);
        @(negedge clock);
        chk1("t5_rel_resp0", bus.respValid_0, 1'b0);
        chk1("t5_rel_ready0", bus.reqReady_0, 1'b1);
        chk1("t5_rel_ready1", bus.reqReady_1, 1'b0);
        cyc();
        @(negedge clock);
        chk1("t5_next_ready1", bus.reqReady_1, 1'b1);
        chk32("t5_rdata0", bus.respData_0, 32'hCAFE0010);
        cyc();
        req0(0, 0, 4'h0, 8'h00, 32'h0, 0);
        req1(0, 0, 4'h0, 8'h00, 32'h0, 0);
        @(negedge clock);
        chk32("t5_rdata1", bus.respData_1, 32'hBEEF0020);
        cyc();
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
